// File: rtl/pkt_head_buffer_if.sv
// -----------------------------------------------------------------------------
// pkt_head_buffer_if
//
// Stream-in / header-vector-out bundle for pkt_head_buffer.
//   i_data_valid, i_data, i_sop, i_eop, i_empty : packet beat stream (upstream)
//   o_data_ready                                : beat accept strobe (buffer)
//   o_phv_valid, o_phv, o_phv_len               : packed header vector (buffer)
//   i_phv_ready                                 : parser takes the vector
//
// Modports:
//   master : the side that sources beats and consumes the vector (upstream/parser)
//   slave  : the header buffer itself
// -----------------------------------------------------------------------------
interface pkt_head_buffer_if #(
    parameter int PHV_WIDTH  = 1024,
    parameter int DATA_WIDTH = 128
);
    localparam int EMPTY_WIDTH = $clog2(DATA_WIDTH / 8);
    localparam int LEN_WIDTH   = $clog2(PHV_WIDTH / 8) + 1;

    logic                   i_data_valid;
    logic [DATA_WIDTH-1:0]  i_data;
    logic                   i_sop;
    logic                   i_eop;
    logic [EMPTY_WIDTH-1:0] i_empty;
    logic                   o_data_ready;
    logic                   o_phv_valid;
    logic [PHV_WIDTH-1:0]   o_phv;
    logic [LEN_WIDTH-1:0]   o_phv_len;
    logic                   i_phv_ready;

    modport master (
        output i_data_valid, i_data, i_sop, i_eop, i_empty, i_phv_ready,
        input  o_data_ready, o_phv_valid, o_phv, o_phv_len
    );

    modport slave (
        input  i_data_valid, i_data, i_sop, i_eop, i_empty, i_phv_ready,
        output o_data_ready, o_phv_valid, o_phv, o_phv_len
    );
endinterface

// File: rtl/pkt_head_buffer.sv
// -----------------------------------------------------------------------------
// pkt_head_buffer
//
// Packs the leading PHV_WIDTH bits of a packet, arriving as DATA_WIDTH-bit
// beats, into a big-endian header vector: packet byte 0 lands in the MSB byte
// of o_phv, so an extractor at offset k reads packet byte k. Bytes past
// PHV_WIDTH are accepted and dropped. The vector and its byte count are held
// stable from the handoff until the next sop beat is accepted.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : beat stream in, header vector out (see pkt_head_buffer_if)
//   o_err          : one-cycle pulse on a protocol error  (PKT_HEAD_BUF_ERR_EN)
//   o_err_cnt      : 16-bit saturating error count        (PKT_HEAD_BUF_ERR_EN)
//
// Build option:
//   PKT_HEAD_BUF_ERR_EN : adds o_err / o_err_cnt. Errors are a non-sop beat
//                         accepted in IDLE and a sop beat that aborts a packet
//                         in FILL or DRAIN. The datapath is identical either way.
// -----------------------------------------------------------------------------
module pkt_head_buffer #(
    parameter int PHV_WIDTH  = 1024,
    parameter int DATA_WIDTH = 128
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
`ifdef PKT_HEAD_BUF_ERR_EN
    output logic            o_err,
    output logic [15:0]     o_err_cnt,
`endif
    pkt_head_buffer_if.slave bus
);
    localparam int BEATS       = PHV_WIDTH / DATA_WIDTH;
    localparam int BEAT_BYTES  = DATA_WIDTH / 8;
    localparam int EMPTY_WIDTH = $clog2(DATA_WIDTH / 8);
    localparam int LEN_WIDTH   = $clog2(PHV_WIDTH / 8) + 1;
    localparam int CNT_WIDTH   = $clog2(BEATS + 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [PHV_WIDTH-1:0]   phv_q, phv_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;

    logic                   accept;
    logic                   start;      // beat opens a new packet at slot 0
    logic                   write;      // beat continues the packet at slot cnt_q
    logic [CNT_WIDTH-1:0]   wr_slot;
    logic [LEN_WIDTH-1:0]   beat_bytes;

    assign accept = bus.i_data_valid & ready_q;

    // i_empty only trims the eop beat; the raw bytes are still stored.
    assign beat_bytes = LEN_WIDTH'(BEAT_BYTES)
                      - (bus.i_eop ? LEN_WIDTH'(bus.i_empty) : '0);

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        phv_d   = phv_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        write   = 1'b0;
        wr_slot = '0;

        unique case (state_q)
            IDLE: begin
                // Non-sop beats here belong to no packet and are dropped.
                if (accept && bus.i_sop) start = 1'b1;
            end
            FILL: begin
                if (accept) begin
                    if (bus.i_sop) begin
                        start = 1'b1;
                    end else begin
                        write = 1'b1;
                        if (bus.i_eop)                             state_d = HOLD;
                        else if (cnt_q == CNT_WIDTH'(BEATS - 1))   state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept) begin
                    if (bus.i_sop)      start   = 1'b1;
                    else if (bus.i_eop) state_d = HOLD;
                end
            end
            HOLD: begin
                // valid_q is always set in HOLD, so i_phv_ready alone completes
                // the handoff.
                if (bus.i_phv_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            phv_d   = '0;
            state_d = bus.i_eop ? HOLD : ((BEATS == 1) ? DRAIN : FILL);
        end

        if (start || write) begin
            wr_slot = start ? '0 : cnt_q;
            // Slot s occupies bits PHV_WIDTH-1-s*DATA_WIDTH downward, which
            // keeps the earliest packet byte in the MSB byte of the vector.
            for (int s = 0; s < BEATS; s++) begin
                if (wr_slot == CNT_WIDTH'(s)) begin
                    phv_d[PHV_WIDTH-1-s*DATA_WIDTH -: DATA_WIDTH] = bus.i_data;
                end
            end
            cnt_d = wr_slot + CNT_WIDTH'(1);
            len_d = (start ? '0 : len_q) + beat_bytes;
        end
    end

    // Handshake outputs are registered copies of the next-state decode, so
    // they change on the clock edge together with the state itself.
    assign ready_d = (state_d != HOLD);
    assign valid_d = (state_d == HOLD);

    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    // NOTE: the header buffer is reset along with the control flops because
    // o_phv must read zero out of reset and across a mid-packet reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            phv_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phv_q   <= phv_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign bus.o_data_ready = ready_q;
    assign bus.o_phv_valid  = valid_q;
    assign bus.o_phv        = phv_q;
    assign bus.o_phv_len    = len_q;

`ifdef PKT_HEAD_BUF_ERR_EN
    logic        err_d, err_q;
    logic [15:0] err_cnt_q, err_cnt_d;

    // A sop beat while a packet is open aborts it; a non-sop beat with no
    // packet open is orphaned. Both are accepted and reported here.
    assign err_d = accept & ((state_q == IDLE) ? ~bus.i_sop
                          : (((state_q == FILL) || (state_q == DRAIN)) & bus.i_sop));

    assign err_cnt_d = (err_d && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err     = err_q;
    assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_head_buffer.sv
// -----------------------------------------------------------------------------
// tb_pkt_head_buffer
//
// Bench for pkt_head_buffer. A byte-level model tracks which packet bytes have
// been captured and whether a vector is being offered; a compare process checks
// every DUT output against it on each falling edge. Directed scenarios add
// literal expectations, followed by a randomized stream.
// -----------------------------------------------------------------------------
module tb_pkt_head_buffer;
    localparam int PHV_W  = 1024;
    localparam int DATA_W = 128;
    localparam int DB     = DATA_W / 8;
    localparam int PB     = PHV_W / 8;
    localparam int BEATS  = PHV_W / DATA_W;

    typedef logic [PHV_W-1:0] vec_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pkt_head_buffer_if #(.PHV_WIDTH(PHV_W), .DATA_WIDTH(DATA_W)) bus ();

`ifdef PKT_HEAD_BUF_ERR_EN
    logic        o_err;
    logic [15:0] o_err_cnt;
`endif

    pkt_head_buffer #(.PHV_WIDTH(PHV_W), .DATA_WIDTH(DATA_W)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
`ifdef PKT_HEAD_BUF_ERR_EN
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt),
`endif
        .bus       (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input vec_t act, input vec_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_bytes [PB];
    int  m_len     = 0;
    int  m_beats   = 0;
    bit  m_in_pkt  = 0;
    bit  m_hold    = 0;
    bit  m_rdy     = 0;
    bit  m_acc;
    bit  m_err     = 0;
    int  m_err_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_bytes[i]) m_bytes[i] = 8'h00;
            m_len = 0; m_beats = 0; m_in_pkt = 0; m_hold = 0; m_rdy = 0;
            m_err = 0; m_err_cnt = 0;
        end else begin
            m_acc = bus.i_data_valid && m_rdy;
            m_err = m_acc && (bus.i_sop ? m_in_pkt : !m_in_pkt);
            if (m_err && m_err_cnt < 65535) m_err_cnt++;
            if (m_hold) begin
                if (bus.i_phv_ready) m_hold = 0;
            end else if (m_acc) begin
                if (bus.i_sop) begin
                    foreach (m_bytes[i]) m_bytes[i] = 8'h00;
                    m_beats = 0; m_len = 0; m_in_pkt = 1;
                end
                if (m_in_pkt) begin
                    if (m_beats < BEATS) begin
                        for (int k = 0; k < DB; k++)
                            m_bytes[m_beats*DB + k] = bus.i_data[DATA_W-1-8*k -: 8];
                        m_len += DB - (bus.i_eop ? int'(bus.i_empty) : 0);
                    end
                    m_beats++;
                    if (bus.i_eop) begin
                        m_in_pkt = 0;
                        m_hold   = 1;
                    end
                end
            end
            m_rdy = !m_hold;
        end
    end

    function automatic vec_t model_phv();
        vec_t v;
        for (int i = 0; i < PB; i++) v[PHV_W-1-8*i -: 8] = m_bytes[i];
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("ready",     vec_t'(bus.o_data_ready), vec_t'(m_rdy));
        check("phv_valid", vec_t'(bus.o_phv_valid),  vec_t'(m_hold));
        check("phv_len",   vec_t'(bus.o_phv_len),    vec_t'(m_len));
        check("phv",       bus.o_phv,                model_phv());
`ifdef PKT_HEAD_BUF_ERR_EN
        check("err",       vec_t'(o_err),            vec_t'(m_err));
        check("err_cnt",   vec_t'(o_err_cnt),        vec_t'(m_err_cnt));
`endif
    end

    // ---------------- stimulus ----------------
    function automatic logic [DATA_W-1:0] fill(input logic [7:0] v);
        return {DB{v}};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [DATA_W-1:0] d, input logic s, input logic e,
                         input logic [3:0] em);
        bus.i_data_valid = 1'b1;
        bus.i_data       = d;
        bus.i_sop        = s;
        bus.i_eop        = e;
        bus.i_empty      = em;
        step(1);
        bus.i_data_valid = 1'b0;
        bus.i_sop        = 1'b0;
        bus.i_eop        = 1'b0;
    endtask

    vec_t exp3, exp_ab, exp12;

    initial begin
        rst_n            = 1'b0;
        bus.i_data_valid = 1'b0;
        bus.i_data       = '0;
        bus.i_sop        = 1'b0;
        bus.i_eop        = 1'b0;
        bus.i_empty      = '0;
        bus.i_phv_ready  = 1'b0;

        // Reset, then idle
        step(3);
        check("rst_ready", vec_t'(bus.o_data_ready), vec_t'(0));
        check("rst_valid", vec_t'(bus.o_phv_valid),  vec_t'(0));
        check("rst_len",   vec_t'(bus.o_phv_len),    vec_t'(0));
        check("rst_phv",   bus.o_phv,                vec_t'(0));
        rst_n = 1'b1;
        step(1);
        check("ready_after_rst", vec_t'(bus.o_data_ready), vec_t'(1));

        // 3-beat packet, eop empty=4
        bus.i_phv_ready = 1'b1;
        exp3 = {fill(8'hA0), fill(8'hA1), fill(8'hA2), 640'h0};
        drive(fill(8'hA0), 1'b1, 1'b0, 4'd0);
        drive(fill(8'hA1), 1'b0, 1'b0, 4'd0);
        check("p3_valid_pre", vec_t'(bus.o_phv_valid), vec_t'(0));
        drive(fill(8'hA2), 1'b0, 1'b1, 4'd4);
        check("p3_valid",  vec_t'(bus.o_phv_valid), vec_t'(1));
        check("p3_len",    vec_t'(bus.o_phv_len),   vec_t'(44));
        check("p3_phv",    bus.o_phv,               exp3);
        check("p3_model",  model_phv(),             exp3);
        step(1);
        check("p3_valid_1cyc", vec_t'(bus.o_phv_valid), vec_t'(0));
        check("p3_phv_stable", bus.o_phv,               exp3);

        // Sop during FILL after 2 beats: abort and restart at slot 0
        exp_ab = {fill(8'hC0), fill(8'hC1), 768'h0};
        drive(fill(8'hB0), 1'b1, 1'b0, 4'd0);
        drive(fill(8'hB1), 1'b0, 1'b0, 4'd0);
        drive(fill(8'hC0), 1'b1, 1'b0, 4'd0);
`ifdef PKT_HEAD_BUF_ERR_EN
        check("abort_err",     vec_t'(o_err),     vec_t'(1));
        check("abort_err_cnt", vec_t'(o_err_cnt), vec_t'(1));
`endif
        drive(fill(8'hC1), 1'b0, 1'b1, 4'd0);
`ifdef PKT_HEAD_BUF_ERR_EN
        check("abort_err_once", vec_t'(o_err), vec_t'(0));
`endif
        check("abort_len", vec_t'(bus.o_phv_len), vec_t'(32));
        check("abort_phv", bus.o_phv,             exp_ab);
        step(1);

        // Non-sop beat in IDLE is dropped
        drive(fill(8'hEE), 1'b0, 1'b0, 4'd0);
        check("orphan_phv", bus.o_phv,             exp_ab);
        check("orphan_len", vec_t'(bus.o_phv_len), vec_t'(32));
`ifdef PKT_HEAD_BUF_ERR_EN
        check("orphan_err", vec_t'(o_err), vec_t'(1));
`endif

        // 12-beat packet: beats 9..12 drained
        exp12 = '0;
        for (int b = 0; b < BEATS; b++)
            exp12[PHV_W-1-b*DATA_W -: DATA_W] = fill(8'(8'h10 + b));
        for (int b = 0; b < 12; b++) begin
            drive(fill(8'(8'h10 + b)), b == 0, b == 11, 4'd3);
            if (b == 10) begin
                check("p12_valid_pre", vec_t'(bus.o_phv_valid),  vec_t'(0));
                check("p12_ready_drn", vec_t'(bus.o_data_ready), vec_t'(1));
            end
        end
        check("p12_valid", vec_t'(bus.o_phv_valid), vec_t'(1));
        check("p12_len",   vec_t'(bus.o_phv_len),   vec_t'(128));
        check("p12_phv",   bus.o_phv,               exp12);
        step(1);

        // Single beat sop=eop, parser stalls 5 cycles
        bus.i_phv_ready = 1'b0;
        drive(fill(8'h5A), 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", vec_t'(bus.o_phv_valid),  vec_t'(1));
            check("hold_ready", vec_t'(bus.o_data_ready), vec_t'(0));
            step(1);
        end
        bus.i_phv_ready = 1'b1;
        check("hold_len", vec_t'(bus.o_phv_len), vec_t'(16));
        step(1);
        check("handoff_valid", vec_t'(bus.o_phv_valid),  vec_t'(0));
        check("handoff_ready", vec_t'(bus.o_data_ready), vec_t'(1));

        // Reset in the middle of a packet
        drive(fill(8'h77), 1'b1, 1'b0, 4'd0);
        drive(fill(8'h78), 1'b0, 1'b0, 4'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", vec_t'(bus.o_data_ready), vec_t'(0));
        check("mid_rst_valid", vec_t'(bus.o_phv_valid),  vec_t'(0));
        check("mid_rst_len",   vec_t'(bus.o_phv_len),    vec_t'(0));
        check("mid_rst_phv",   bus.o_phv,                vec_t'(0));
        step(2);
        rst_n = 1'b1;
        step(1);
        check("mid_rst_ready_rel", vec_t'(bus.o_data_ready), vec_t'(1));

        // Randomized stream
        for (int c = 0; c < 3000; c++) begin
            bus.i_data_valid = ($urandom_range(3) != 0);
            bus.i_data       = {$urandom, $urandom, $urandom, $urandom};
            bus.i_sop        = ($urandom_range(7) == 0);
            bus.i_eop        = ($urandom_range(5) == 0);
            bus.i_empty      = 4'($urandom_range(15));
            bus.i_phv_ready  = ($urandom_range(2) == 0);
            step(1);
        end
        bus.i_data_valid = 1'b0;
        bus.i_phv_ready  = 1'b1;
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
